// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: op encodings, data width
// and the lock FSM state type.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_FLIP = 3'b101;
  localparam logic [2:0] OP_LSR  = 3'b110;
  localparam logic [2:0] OP_LSL  = 3'b111;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_16.sv
// 16-bit combinational ALU; shift and bit-flip amounts come from b[3:0].
module alu_16
  import alu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_FLIP: y = a ^ (DATA_W'(1) << b[3:0]);
      OP_LSR:  y = a >> b[3:0];
      OP_LSL:  y = a << b[3:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping
// modulo NUM_REQ.
module alu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = ID_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one alu_16 among NUM_REQ requesters, with a
// single-entry tagged response register and an optional ownership lock.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [3*NUM_REQ-1:0]        req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]          req_lock,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        locked
);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  logic                can_issue;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                accept;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b, alu_y;

  alu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // While locked only the owner is eligible, even if it is idle.
  always_comb begin
    can_issue = !rsp_valid || rsp_ready;
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      gnt_idx = owner_q;
      gnt_any = req_valid[owner_q];
      if (gnt_any && can_issue) req_ready[owner_q] = 1'b1;
    end else begin
      gnt_idx = pick_idx;
      gnt_any = pick_any;
      if (can_issue) req_ready = pick_grant;
    end
    accept = gnt_any && can_issue;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  alu_16 u_alu (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (accept) begin
      if (state_q == ST_UNLOCKED && req_lock[gnt_idx]) begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end else if (state_q == ST_LOCKED && !req_lock[gnt_idx]) begin
        state_d = ST_UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNLOCKED;
      owner_q   <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (accept) begin
        ptr_q     <= gnt_idx;
        rsp_valid <= 1'b1;
        rsp_data  <= alu_y;
        rsp_id    <= gnt_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic
// against a behavioural arbiter/ALU model.
module tb_alu_share_arb;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [3*N-1:0]  req_op;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]  req_lock;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          locked;

  int vectors;
  int miscompares;

  alu_share_arb #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_lock  (req_lock),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sh;
    sh = int'(b[3:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a ^ (16'h0001 << sh);
      3'd6: return a >> sh;
      default: return a << sh;
    endcase
  endfunction

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic lk);
    req_valid[i]        = v;
    req_op[3*i +: 3]    = op;
    req_a[16*i +: 16]   = a;
    req_b[16*i +: 16]   = b;
    req_lock[i]         = lk;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    vectors++; if (rsp_data !== 16'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
    vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, 16'(i), 16'd1, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (req_ready !== (4'b1 << (k % N))) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b1 << (k % N));
      end
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % N) || rsp_data !== 16'(k % N + 1)) begin
        miscompares++;
        $display("FAIL rr_rsp[%0d]: got v=%0b id=%0d data=%0h expected v=1 id=%0d data=%0h",
                 k, rsp_valid, rsp_id, rsp_data, k % N, k % N + 1);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(2, 1'b1, 3'd7, 16'h00F0, 16'd4, 1'b0);
    rsp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_first_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    set_req(2, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b1, 3'd1, 16'd10, 16'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h0F00 || rsp_id !== 2'd2) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%0b id=%0d data=%0h expected v=1 id=2 data=0f00", k, rsp_valid, rsp_id, rsp_data);
      end
      vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL bp_stall[%0d]: got %b expected 0000", k, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd7) begin
      miscompares++; $display("FAIL bp_next_rsp: got v=%0b id=%0d data=%0h expected v=1 id=1 data=7", rsp_valid, rsp_id, rsp_data);
    end
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 3'd0, 16'd100, 16'd1, 1'b1);
    set_req(3, 1'b1, 3'd0, 16'd7, 16'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL lock_ready[%0d]: got %b expected 0010", k, req_ready); end
      vectors++; if (locked !== (k != 0)) begin miscompares++; $display("FAIL lock_state_pre[%0d]: got %0b expected %0b", k, locked, k != 0); end
      @(posedge clk); #1;
      vectors++;
      if (rsp_id !== 2'd1 || rsp_data !== 16'(101 + k)) begin
        miscompares++; $display("FAIL lock_rsp[%0d]: got id=%0d data=%0d expected id=1 data=%0d", k, rsp_id, rsp_data, 101 + k);
      end
      vectors++; if (locked !== (k < 2)) begin miscompares++; $display("FAIL lock_state_post[%0d]: got %0b expected %0b", k, locked, k < 2); end
      set_req(1, k < 2, 3'd0, 16'(101 + k), 16'd1, k + 1 < 2);
    end
    #1;
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL lock_after_ready: got %b expected 1000", req_ready); end
    @(posedge clk); #1;
    vectors++;
    if (rsp_id !== 2'd3 || rsp_data !== 16'h000E || locked !== 1'b0) begin
      miscompares++; $display("FAIL lock_after_rsp: got id=%0d data=%0h locked=%0b expected id=3 data=e locked=0", rsp_id, rsp_data, locked);
    end
    req_valid = '0;
  endtask

  task automatic test_op_sweep();
    logic [2:0]  ops  [5] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [15:0] as   [5] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF};
    logic [15:0] bs   [5] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0001};
    logic [15:0] exps [5] = '{16'h7FFE, 16'h8002, 16'h8009, 16'h1000, 16'h0000};
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, ops[k], as[k], bs[k], 1'b0);
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exps[k]) begin
        miscompares++;
        $display("FAIL op_sweep[%0d]: got v=%0b id=%0d data=%0h expected v=1 id=0 data=%0h", k, rsp_valid, rsp_id, rsp_data, exps[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 1'b1, 3'd0, 16'd5, 16'd5, 1'b1);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || locked !== 1'b1) begin
      miscompares++; $display("FAIL arst_setup: got v=%0b locked=%0b expected v=1 locked=1", rsp_valid, locked);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 2'd0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_clear: got v=%0b id=%0d data=%0h locked=%0b expected all 0", rsp_valid, rsp_id, rsp_data, locked);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, 16'(i), 16'd1, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd1) begin
      miscompares++; $display("FAIL arst_first_grant: got v=%0b id=%0d data=%0h expected v=1 id=0 data=1", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int          m_ptr, m_owner, m_rid, g, last_g;
    bit          m_lock, m_rv, acc, can;
    logic [15:0] m_rd, nxt;
    logic [N-1:0] exp_ready;
    int          waits [N];
    do_reset();
    m_ptr = N - 1; m_owner = 0; m_rid = 0; m_lock = 0; m_rv = 0; m_rd = '0; last_g = -1;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && i != last_g))
          set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), $urandom_range(0, 3) == 0);
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      can = !m_rv || rsp_ready;
      if (m_lock) g = req_valid[m_owner] ? m_owner : -1;
      else        g = model_pick(req_valid, m_ptr);
      acc = (g >= 0) && can;
      exp_ready = acc ? (4'b1 << g) : 4'b0;
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready);
      end
      vectors++;
      if ($countones(req_ready) > 1) begin
        miscompares++; $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", cyc, req_ready);
      end
      nxt = '0;
      if (acc) begin
        nxt = alu_ref(req_op[3*g +: 3], req_a[16*g +: 16], req_b[16*g +: 16]);
        if (!m_lock) begin
          for (int i = 0; i < N; i++) if (i != g && req_valid[i]) waits[i]++;
          waits[g] = 0;
          vectors++;
          for (int i = 0; i < N; i++) begin
            if (waits[i] > N - 1) begin
              miscompares++; $display("FAIL rnd_fair[%0d]: requester %0d waited %0d accepts, expected <= %0d", cyc, i, waits[i], N - 1);
            end
          end
        end else begin
          waits[g] = 0;
        end
      end
      @(posedge clk);
      if (acc) begin
        m_rv = 1; m_rd = nxt; m_rid = g; m_ptr = g;
        if (!m_lock && req_lock[g]) begin m_lock = 1; m_owner = g; end
        else if (m_lock && !req_lock[g]) m_lock = 0;
      end else if (rsp_ready) begin
        m_rv = 0;
      end
      last_g = acc ? g : -1;
      #1;
      vectors++;
      if (rsp_valid !== m_rv || locked !== m_lock) begin
        miscompares++; $display("FAIL rnd_ctrl[%0d]: got v=%0b locked=%0b expected v=%0b locked=%0b", cyc, rsp_valid, locked, m_rv, m_lock);
      end
      if (m_rv) begin
        vectors++;
        if (rsp_data !== m_rd || rsp_id !== 2'(m_rid)) begin
          miscompares++; $display("FAIL rnd_rsp[%0d]: got id=%0d data=%0h expected id=%0d data=%0h", cyc, rsp_id, rsp_data, m_rid, m_rd);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_lock();
    test_op_sweep();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
